product_accumulator: RTL and testbench

Streaming accumulator directly downstream of the combinational array multiplier. It consumes one 2N-bit unsigned product per accepted beat and sums a group of products terminated by `last_i`, e.g. to form a dot product. It presents the saturated group sum on a valid/ready output port and holds it until the consumer takes it. It adds the register, control and handshake layer that the purely combinational multiplier lacks.

---
 rtl/product_accumulator.sv | 88 ++++++++
 tb/tb_product_accumulator.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/product_accumulator.sv
// Streaming accumulator for multiplier products: sums a last-terminated group
// with saturation and presents the result on a valid/ready port until taken.
module product_accumulator #(
  parameter int N     = 4,
  parameter int ACC_W = 2*N+4,
  parameter int CNT_W = 8
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               clear_i,
  input  logic               valid_i,
  input  logic [2*N-1:0]     product_i,
  input  logic               last_i,
  output logic               ready_o,
  output logic [ACC_W-1:0]   sum_o,
  output logic               sum_valid_o,
  input  logic               sum_ready_i,
  output logic [CNT_W-1:0]   count_o,
  output logic               overflow_o
);

  typedef enum logic {ACCUM, HOLD} state_t;

  state_t             state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               ovf_q, ovf_d;

  logic [ACC_W:0]     sum_full;
  logic               beat;

  // The accumulator is already saturated, so one extra bit holds any true sum.
  assign sum_full = {1'b0, acc_q} + {{(ACC_W+1-2*N){1'b0}}, product_i};
  assign beat     = valid_i && (state_q == ACCUM);

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    if (clear_i) begin
      state_d = ACCUM;
      acc_d   = '0;
      count_d = '0;
      ovf_d   = 1'b0;
    end else begin
      unique case (state_q)
        ACCUM: if (beat) begin
          acc_d   = sum_full[ACC_W] ? {ACC_W{1'b1}} : sum_full[ACC_W-1:0];
          count_d = (count_q == {CNT_W{1'b1}}) ? count_q : count_q + 1'b1;
          ovf_d   = ovf_q | sum_full[ACC_W];
          if (last_i) state_d = HOLD;
        end
        HOLD: if (sum_ready_i) begin
          state_d = ACCUM;
          acc_d   = '0;
          count_d = '0;
          ovf_d   = 1'b0;
        end
        default: state_d = ACCUM;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ACCUM;
      acc_q   <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  assign ready_o     = (state_q == ACCUM);
  assign sum_valid_o = (state_q == HOLD);
  assign sum_o       = acc_q;
  assign count_o     = count_q;
  assign overflow_o  = ovf_q;

endmodule

// File: tb/tb_product_accumulator.sv
// Directed self-checking bench for product_accumulator (N=4, ACC_W=12, CNT_W=8).
// Inputs change and outputs are sampled on the falling edge.
module tb_product_accumulator;

  localparam int N     = 4;
  localparam int ACC_W = 12;
  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             clear = 1'b0;
  logic             valid = 1'b0;
  logic [2*N-1:0]   product = '0;
  logic             last = 1'b0;
  logic             ready;
  logic [ACC_W-1:0] sum;
  logic             sum_valid;
  logic             sum_ready = 1'b0;
  logic [CNT_W-1:0] count;
  logic             overflow;

  int total = 0;
  int bad   = 0;

  product_accumulator #(.N(N), .ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .clear_i     (clear),
    .valid_i     (valid),
    .product_i   (product),
    .last_i      (last),
    .ready_o     (ready),
    .sum_o       (sum),
    .sum_valid_o (sum_valid),
    .sum_ready_i (sum_ready),
    .count_o     (count),
    .overflow_o  (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check_result(input string tag, input int s, input int c, input int o);
    check({tag, " valid"}, 32'(sum_valid), 1);
    check({tag, " ready"}, 32'(ready), 0);
    check({tag, " sum"},   32'(sum), s);
    check({tag, " count"}, 32'(count), c);
    check({tag, " ovf"},   32'(overflow), o);
  endtask

  task automatic send_group(input int p, input int g);
    for (int i = 0; i < g; i++) begin
      valid   = 1'b1;
      product = p[2*N-1:0];
      last    = (i == g-1);
      tick();
    end
    valid = 1'b0;
    last  = 1'b0;
  endtask

  task automatic handshake();
    sum_ready = 1'b1;
    tick();
    sum_ready = 1'b0;
  endtask

  initial begin
    repeat (2) tick();
    rst = 1'b0;
    check("rst ready", 32'(ready), 1);
    check("rst valid", 32'(sum_valid), 0);
    check("rst sum",   32'(sum), 0);
    check("rst count", 32'(count), 0);
    check("rst ovf",   32'(overflow), 0);

    // Partial sum is visible mid-group, then the full group of 4 x 225.
    send_group(225, 0);
    valid = 1'b1; product = 8'd225; last = 1'b0;
    tick(); tick();
    valid = 1'b0;
    check("partial sum",   32'(sum), 450);
    check("partial count", 32'(count), 2);
    check("partial ready", 32'(ready), 1);
    clear = 1'b1; tick(); clear = 1'b0;
    send_group(225, 4);
    check_result("g4x225", 900, 4, 0);

    // Beats offered during HOLD are ignored.
    valid = 1'b1; product = 8'd7; last = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("hold sum",   32'(sum), 900);
      check("hold count", 32'(count), 4);
      check("hold ready", 32'(ready), 0);
    end
    valid = 1'b0; last = 1'b0;
    handshake();
    check("post hs ready", 32'(ready), 1);
    check("post hs count", 32'(count), 0);
    check("post hs valid", 32'(sum_valid), 0);

    // Saturation: 19 x 225 = 4275 clamps to 4095.
    send_group(225, 19);
    check_result("sat", 4095, 19, 1);
    handshake();
    send_group(3, 1);
    check_result("after sat", 3, 1, 0);
    handshake();

    // Back-to-back single-beat groups with the consumer always ready.
    valid = 1'b1; product = 8'd10; last = 1'b1; sum_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      check("b2b valid", 32'(sum_valid), (i % 2 == 0) ? 1 : 0);
      check("b2b sum",   32'(sum),       (i % 2 == 0) ? 10 : 0);
      check("b2b count", 32'(count),     (i % 2 == 0) ? 1 : 0);
    end
    valid = 1'b0; last = 1'b0; sum_ready = 1'b0;

    // Clear wins over a coincident beat.
    send_group(5, 0);
    valid = 1'b1; product = 8'd5; last = 1'b0;
    tick(); tick();
    check("pre clr sum", 32'(sum), 10);
    product = 8'd9; clear = 1'b1;
    tick();
    clear = 1'b0; valid = 1'b0;
    check("clr sum",   32'(sum), 0);
    check("clr count", 32'(count), 0);
    check("clr ready", 32'(ready), 1);
    send_group(4, 1);
    check_result("after clr", 4, 1, 0);
    handshake();

    // Asynchronous reset while holding a result.
    send_group(225, 4);
    check_result("pre arst", 900, 4, 0);
    #2 rst = 1'b1;
    #1;
    check("arst sum",   32'(sum), 0);
    check("arst valid", 32'(sum_valid), 0);
    check("arst ready", 32'(ready), 1);
    check("arst count", 32'(count), 0);
    check("arst ovf",   32'(overflow), 0);
    tick();
    rst = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
